// File: rtl/encap_ctrl.sv
// encap_ctrl -- per-packet controller for the Encap_Head datapath.
//
// The parser pushes one rule ID per packet into a small context FIFO. Head/meta
// slices stream through with exactly one cycle of latency. On every start slice
// a context is popped, the rule table is read, and the rule fields are
// registered so they line up with that start slice on o_head. The fields then
// hold until the next start slice. The rule table is written through a simple
// config port.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_ctx_valid/i_ctx_ruleId  parser context push; o_ctx_ready = FIFO not full
//   i_head/i_meta             slice + tag in (tag occupies the low TAG_WIDTH bits)
//   o_head/o_meta             same slices delayed one cycle, to Encap_Head
//   o_headShift, o_metaSliceOffset, o_metaDataOffset, o_encapLength,
//   o_encapField              rule fields for the current packet
//   i_cfg_wren/addr/wdata     rule table write
//                             wdata = {encapField,encapLength,metaDataOffset,
//                                      metaSliceOffset,headShift}
//   o_miss_pulse              start slice seen while the FIFO was empty
//   o_err_pulse               start slice inside a packet, or out-of-range rule ID
//
// Optional build macro ENCAP_CTRL_STATS_EN adds the saturating 32-bit counters
// o_stat_pkts / o_stat_miss / o_stat_err.
//
// Width macros (HEAD_WIDTH, META_WIDTH, TAG_WIDTH, HEAD_SHIFT_WIDTH,
// META_SHIFT_WIDTH, ENCAP_WIDTH) and tag bit positions may be supplied by the
// surrounding build; local defaults are provided below.

`ifndef HEAD_WIDTH
`define HEAD_WIDTH 32
`endif
`ifndef META_WIDTH
`define META_WIDTH 32
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 4
`endif
`ifndef HEAD_SHIFT_WIDTH
`define HEAD_SHIFT_WIDTH 6
`endif
`ifndef META_SHIFT_WIDTH
`define META_SHIFT_WIDTH 4
`endif
`ifndef ENCAP_WIDTH
`define ENCAP_WIDTH 16
`endif
`ifndef TAG_VALID_BIT
`define TAG_VALID_BIT 0
`endif
`ifndef TAG_START_BIT
`define TAG_START_BIT 1
`endif
`ifndef TAG_TAIL_BIT
`define TAG_TAIL_BIT 2
`endif

module encap_ctrl #(
  parameter int RULE_NUM  = 16,
  parameter int RULE_ID_W = 4,
  parameter int CTX_DEPTH = 8   // power of 2, >= 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_ctx_valid,
  input  logic [RULE_ID_W-1:0]                 i_ctx_ruleId,
  output logic                                 o_ctx_ready,
  input  logic [`HEAD_WIDTH+`TAG_WIDTH-1:0]    i_head,
  input  logic [`META_WIDTH+`TAG_WIDTH-1:0]    i_meta,
  output logic [`HEAD_WIDTH+`TAG_WIDTH-1:0]    o_head,
  output logic [`META_WIDTH+`TAG_WIDTH-1:0]    o_meta,
  output logic [`HEAD_SHIFT_WIDTH-1:0]         o_headShift,
  output logic [3:0]                           o_metaSliceOffset,
  output logic [`HEAD_SHIFT_WIDTH-1:0]         o_metaDataOffset,
  output logic [`META_SHIFT_WIDTH-1:0]         o_encapLength,
  output logic [`ENCAP_WIDTH-1:0]              o_encapField,
  input  logic                                 i_cfg_wren,
  input  logic [RULE_ID_W-1:0]                 i_cfg_addr,
  input  logic [`ENCAP_WIDTH+`META_SHIFT_WIDTH+2*`HEAD_SHIFT_WIDTH+4-1:0] i_cfg_wdata,
`ifdef ENCAP_CTRL_STATS_EN
  output logic [31:0]                          o_stat_pkts,
  output logic [31:0]                          o_stat_miss,
  output logic [31:0]                          o_stat_err,
`endif
  output logic                                 o_miss_pulse,
  output logic                                 o_err_pulse
);

  localparam int HSW    = `HEAD_SHIFT_WIDTH;
  localparam int MSW    = `META_SHIFT_WIDTH;
  localparam int EW     = `ENCAP_WIDTH;
  localparam int RULE_W = EW + MSW + 2*HSW + 4;
  localparam int PTR_W  = $clog2(CTX_DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(CTX_DEPTH);

  typedef enum logic {IDLE, PKT} state_t;

  // ---------------------------------------------------------------- decode
  logic start, tail_end;
  assign start    = i_head[`TAG_START_BIT];
  assign tail_end = i_head[`TAG_TAIL_BIT] & i_head[`TAG_VALID_BIT];

  // ---------------------------------------------------------- context FIFO
  logic [RULE_ID_W-1:0] ctx_mem [CTX_DEPTH];
  logic [PTR_W-1:0]     wptr, rptr;
  logic [PTR_W:0]       cnt;
  logic                 full, empty, push, pop;
  logic [RULE_ID_W-1:0] head_id;

  assign full        = (cnt == CNT_FULL);
  assign empty       = (cnt == '0);
  assign o_ctx_ready = ~i_rst & ~full;
  assign pop         = start & ~empty;
  // A pop frees a slot in the same cycle, so a push is taken even when full.
  assign push        = i_ctx_valid & (~full | pop);
  assign head_id     = ctx_mem[rptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < CTX_DEPTH; i++) ctx_mem[i] <= '0;
    end else begin
      if (push) begin
        ctx_mem[wptr] <= i_ctx_ruleId;
        wptr          <= wptr + PTR_ONE;
      end
      if (pop) rptr <= rptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------ range qualifiers
  // Only elaborate the compare when the index width can exceed the table.
  logic id_ok, addr_ok;
  generate
    if (RULE_NUM < (1 << RULE_ID_W)) begin : g_rng
      assign id_ok   = (int'(head_id)    < RULE_NUM);
      assign addr_ok = (int'(i_cfg_addr) < RULE_NUM);
    end else begin : g_full_rng
      assign id_ok   = 1'b1;
      assign addr_ok = 1'b1;
    end
  endgenerate

  // ------------------------------------------------------------ rule table
  logic [RULE_W-1:0]    rule_tab [RULE_NUM];
  logic [RULE_ID_W-1:0] sel_id;

  // Empty FIFO or bad ID falls back to the bypass rule in entry 0.
  assign sel_id = (pop && id_ok) ? head_id : '0;

  // The lookup below reads the table at the same edge a write lands, so a
  // same-cycle write to the looked-up entry is seen only by later packets.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RULE_NUM; i++) rule_tab[i] <= '0;
    end else if (i_cfg_wren && addr_ok) begin
      rule_tab[i_cfg_addr] <= i_cfg_wdata;
    end
  end

  // ---------------------------------------------- stream, FSM and fields
  state_t            state;
  logic [RULE_W-1:0] rule_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      o_head       <= '0;
      o_meta       <= '0;
      rule_q       <= '0;
      o_miss_pulse <= 1'b0;
      o_err_pulse  <= 1'b0;
    end else begin
      o_head       <= i_head;
      o_meta       <= i_meta;
      o_miss_pulse <= start & empty;
      o_err_pulse  <= start & ((state == PKT) | (pop & ~id_ok));
      if (start) rule_q <= rule_tab[sel_id];
      unique case (state)
        IDLE: if (start && !tail_end) state <= PKT;
        // A start inside a packet begins a new packet; a start+tail slice
        // closes it immediately.
        PKT:  if (tail_end) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_headShift       = rule_q[HSW-1:0];
  assign o_metaSliceOffset = rule_q[HSW +: 4];
  assign o_metaDataOffset  = rule_q[HSW+4 +: HSW];
  assign o_encapLength     = rule_q[2*HSW+4 +: MSW];
  assign o_encapField      = rule_q[2*HSW+4+MSW +: EW];

`ifdef ENCAP_CTRL_STATS_EN
  // ------------------------------------------------- saturating counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stat_pkts <= '0;
      o_stat_miss <= '0;
      o_stat_err  <= '0;
    end else begin
      if (start && o_stat_pkts != '1) o_stat_pkts <= o_stat_pkts + 32'd1;
      if (o_miss_pulse && o_stat_miss != '1) o_stat_miss <= o_stat_miss + 32'd1;
      if (o_err_pulse && o_stat_err != '1) o_stat_err <= o_stat_err + 32'd1;
    end
  end
`endif

endmodule
